// File: rtl/vedic_pkg.sv
// Shared state encoding, partial-product indices and shift amounts for the
// time-shared vedic 16x16 multiplier.
package vedic_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PP0  = 3'd1;
  localparam logic [2:0] S_PP1  = 3'd2;
  localparam logic [2:0] S_PP2  = 3'd3;
  localparam logic [2:0] S_PP3  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_PP0  = S_PP0,
    ST_PP1  = S_PP1,
    ST_PP2  = S_PP2,
    ST_PP3  = S_PP3,
    ST_DONE = S_DONE
  } state_e;

  // Index bit 1 selects the a-half, bit 0 selects the b-half.
  localparam logic [1:0] PP0_IDX = 2'd0;
  localparam logic [1:0] PP1_IDX = 2'd1;
  localparam logic [1:0] PP2_IDX = 2'd2;
  localparam logic [1:0] PP3_IDX = 2'd3;

  localparam logic [4:0] PP0_SHIFT = 5'd0;
  localparam logic [4:0] PP1_SHIFT = 5'd8;
  localparam logic [4:0] PP2_SHIFT = 5'd8;
  localparam logic [4:0] PP3_SHIFT = 5'd16;

  function automatic logic [4:0] pp_shift(input logic [1:0] idx);
    case (idx)
      PP0_IDX: return PP0_SHIFT;
      PP1_IDX: return PP1_SHIFT;
      PP2_IDX: return PP2_SHIFT;
      PP3_IDX: return PP3_SHIFT;
      default: return PP0_SHIFT;
    endcase
  endfunction

  function automatic state_e pp_state(input logic [1:0] idx);
    case (idx)
      PP0_IDX: return ST_PP0;
      PP1_IDX: return ST_PP1;
      PP2_IDX: return ST_PP2;
      PP3_IDX: return ST_PP3;
      default: return ST_PP0;
    endcase
  endfunction

  function automatic logic [1:0] pp_index(input state_e st);
    case (st)
      ST_PP1:  return PP1_IDX;
      ST_PP2:  return PP2_IDX;
      ST_PP3:  return PP3_IDX;
      default: return PP0_IDX;
    endcase
  endfunction

  function automatic logic pp_live(input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] idx);
    logic [7:0] ah;
    logic [7:0] bh;
    ah = idx[1] ? a[15:8] : a[7:0];
    bh = idx[0] ? b[15:8] : b[7:0];
    return (ah != 8'h00) && (bh != 8'h00);
  endfunction

  // Lowest partial product at or after 'first' that must be computed; DONE if none.
  function automatic state_e seek_pp(input logic [2:0] first, input logic [15:0] a,
                                     input logic [15:0] b, input logic skip);
    state_e nxt;
    nxt = ST_DONE;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= first) && (!skip || pp_live(a, b, 2'(i)))) begin
        nxt = pp_state(2'(i));
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Combinational 8x8 unsigned vedic multiplier: four 4x4 vertical/crosswise
// products combined at their nibble weights.
module vedic_8x8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [7:0] q0_s;
  logic [7:0] q1_s;
  logic [7:0] q2_s;
  logic [7:0] q3_s;

  assign q0_s = {4'h0, a_i[3:0]} * {4'h0, b_i[3:0]};
  assign q1_s = {4'h0, a_i[7:4]} * {4'h0, b_i[3:0]};
  assign q2_s = {4'h0, a_i[3:0]} * {4'h0, b_i[7:4]};
  assign q3_s = {4'h0, a_i[7:4]} * {4'h0, b_i[7:4]};

  assign p_o = {8'h00, q0_s} + {4'h0, q1_s, 4'h0} + {4'h0, q2_s, 4'h0} + {q3_s, 8'h00};

endmodule

// File: rtl/vedic_16x16_seq.sv
// Sequential 16x16 unsigned multiplier sharing one vedic_8x8 core over four
// partial-product cycles, with valid/ready handshakes on both sides.
module vedic_16x16_seq
  import vedic_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  state_e      state_q;
  state_e      state_d;
  logic [15:0] a_q;
  logic [15:0] a_d;
  logic [15:0] b_q;
  logic [15:0] b_d;
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [31:0] out_q;
  logic [31:0] out_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic [1:0]  pp_idx_s;
  logic [7:0]  core_a_s;
  logic [7:0]  core_b_s;
  logic [15:0] prod_s;

  assign pp_idx_s = pp_index(state_q);
  assign core_a_s = pp_idx_s[1] ? a_q[15:8] : a_q[7:0];
  assign core_b_s = pp_idx_s[0] ? b_q[15:8] : b_q[7:0];

  vedic_8x8 u_core (
    .a_i (core_a_s),
    .b_i (core_b_s),
    .p_o (prod_s)
  );

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 32'h0000_0000;
          state_d = seek_pp(3'd0, a, b, SKIP_ZERO);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PP0, ST_PP1, ST_PP2, ST_PP3: begin
        acc_d   = acc_q + ({16'h0000, prod_s} << pp_shift(pp_idx_s));
        state_d = seek_pp({1'b0, pp_idx_s} + 3'd1, a_q, b_q, SKIP_ZERO);
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // The result register follows the accumulator only while DONE is entered or held.
    out_d = (state_d == ST_DONE) ? acc_d : out_q;
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      acc_q       <= 32'h0000_0000;
      out_q       <= 32'h0000_0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vedic_16x16_seq.sv
// Scoreboard bench for vedic_16x16_seq: one instance per SKIP_ZERO setting,
// directed vectors plus a random sweep checked against a*b and expected latency.
module tb_vedic_16x16_seq;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          acc_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_s  [2];
  logic        in_ready_s  [2];
  logic [15:0] a_s         [2];
  logic [15:0] b_s         [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic [31:0] out_s       [2];
  logic        busy_s      [2];

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          cur = 0;
  bit          rnd_stall = 1'b0;
  logic        ready_lvl = 1'b1;
  bit          seen = 1'b0;
  bit          chk_idle = 1'b0;
  logic [31:0] held = 32'h0;

  vedic_16x16_seq #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .out(out_s[0]), .busy(busy_s[0])
  );

  vedic_16x16_seq #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .out(out_s[1]), .busy(busy_s[1])
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // out_ready driver: a fixed level, or random stalls.
  initial forever begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      out_ready_s[k] = rnd_stall ? 1'($urandom_range(0, 1)) : ready_lvl;
    end
  end

  // Monitor: latency on first valid, stability while stalled, data on handshake.
  initial forever begin
    @(negedge clk);
    if (chk_idle) begin
      chk("idle_in_ready", 32'(in_ready_s[cur]), 32'd1);
      chk("idle_busy", 32'(busy_s[cur]), 32'd0);
      chk_idle = 1'b0;
    end
    if (!rst && out_valid_s[cur]) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid_s[cur]), 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          held = out_s[cur];
          chk("latency", 32'(cyc - exp_q[0].acc_edge + 1), 32'(exp_q[0].lat));
        end else begin
          chk("hold_stable", out_s[cur], held);
        end
        if (out_ready_s[cur]) begin
          chk("product", out_s[cur], exp_q[0].prod);
          void'(exp_q.pop_front());
          seen = 1'b0;
          chk_idle = 1'b1;
        end
      end
    end
  end

  task automatic issue(input int k, input logic [15:0] av, input logic [15:0] bv,
                       input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk);
    #1;
    in_valid_s[k] = 1'b1;
    a_s[k] = av;
    b_s[k] = bv;
    @(negedge clk);
    while (!in_ready_s[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_s[k]) begin
      chk("accept_timeout", 32'(in_ready_s[k]), 32'd1);
    end else begin
      e.prod = {16'h0000, av} * {16'h0000, bv};
      e.lat = lat;
      e.acc_edge = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid_s[k] = 1'b0;
    a_s[k] = 16'($urandom);
    b_s[k] = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    seen = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic int lat_model(input int k, input logic [15:0] av, input logic [15:0] bv);
    int n;
    logic [7:0] ah;
    logic [7:0] bh;
    if (k == 0) begin
      return 5;
    end
    n = 1;
    for (int i = 0; i < 4; i++) begin
      ah = (i >= 2) ? av[15:8] : av[7:0];
      bh = (i % 2 == 1) ? bv[15:8] : bv[7:0];
      if (ah != 8'h00 && bh != 8'h00) n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] rnd_operand();
    logic [7:0] lo;
    logic [7:0] hi;
    lo = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    hi = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    return {hi, lo};
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid_s[k] = 1'b0;
      a_s[k] = 16'h0000;
      b_s[k] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", 32'(in_ready_s[k]), 32'd1);
      chk("rst_out_valid", 32'(out_valid_s[k]), 32'd0);
      chk("rst_busy", 32'(busy_s[k]), 32'd0);
      chk("rst_out", out_s[k], 32'h0000_0000);
    end

    // Basic products, SKIP_ZERO=0.
    cur = 0;
    issue(0, 16'h1234, 16'h5678, 5);
    chk("in_ready_fall", 32'(in_ready_s[0]), 32'd0);
    chk("busy_rise", 32'(busy_s[0]), 32'd1);
    drain();
    chk("expected_1234x5678", 32'h0626_0060, {16'h0000, 16'h1234} * {16'h0000, 16'h5678});
    issue(0, 16'hFFFF, 16'hFFFF, 5);
    issue(0, 16'h0001, 16'h0001, 5);
    drain();

    // Backpressure with ignored operand pulses.
    ready_lvl = 1'b0;
    issue(0, 16'h00AB, 16'h00CD, 5);
    n = 0;
    while (!out_valid_s[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(out_valid_s[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid_s[0] = (i % 2 == 0);
      a_s[0] = 16'hFFFF;
      b_s[0] = 16'(16'h0101 * i);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready_s[0]), 32'd0);
      chk("bp_out_valid", 32'(out_valid_s[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    ready_lvl = 1'b1;
    drain();

    // Zero skipping.
    cur = 1;
    issue(1, 16'h00FF, 16'h0102, 3);
    issue(1, 16'h0000, 16'hBEEF, 1);
    issue(1, 16'h0100, 16'h0100, 2);
    issue(1, 16'h1234, 16'h5678, 5);
    drain();

    // Reset during PP2 discards the operation.
    cur = 0;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b1;
    a_s[0] = 16'h1111;
    b_s[0] = 16'h2222;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready_s[0]), 32'd1);
    chk("midrst_busy", 32'(busy_s[0]), 32'd0);
    chk("midrst_out_valid", 32'(out_valid_s[0]), 32'd0);
    chk("midrst_out", out_s[0], 32'h0000_0000);
    issue(0, 16'h0003, 16'h0005, 5);
    drain();

    // Random sweep with random consumer stalls for both variants.
    rnd_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cur = k;
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] ra;
        logic [15:0] rb;
        ra = rnd_operand();
        rb = rnd_operand();
        issue(k, ra, rb, lat_model(k, ra, rb));
      end
      drain();
    end
    rnd_stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
